// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle CPU: PC, instruction register, imem req/ack fetch FSM,
// field decode and next-PC selection (sequential / beq / j).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        PCWre,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [5:0]  Opcode,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        pc_err,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, ir_q, pc_next, branch_off;
  logic        ir_valid_q, pc_err_q;

  // Handshake: imem_req and imem_addr stay constant from the edge that enters REQ
  // until the edge where imem_ack is seen high; that edge consumes the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_start) state_nxt = REQ;
      REQ:     if (imem_ack)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    pc_next = pc_plus4;
    if (Jump)                 pc_next = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    else if (Branch && Zero)  pc_next = pc_plus4 + branch_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      ir_valid_q <= 1'b0;
      pc_err_q   <= 1'b0;
    end else begin
      if (state == IDLE && PCWre) begin
        pc_q       <= pc_next;
        ir_valid_q <= 1'b0;
      end
      // PC must not move under an outstanding fetch; flag the controller bug instead.
      if (state == REQ && PCWre) pc_err_q <= 1'b1;
      if (state == REQ && imem_ack) begin
        ir_q       <= imem_rdata;
        ir_valid_q <= 1'b1;
      end
    end
  end

  assign imem_req   = (state == REQ);
  assign fetch_busy = (state == REQ);
  assign dbg_state  = state;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir_valid   = ir_valid_q;
  assign pc_err     = pc_err_q;
  assign Opcode     = ir_q[31:26];
  assign func       = ir_q[5:0];
  assign rs         = ir_q[25:21];
  assign rt         = ir_q[20:16];
  assign rd         = ir_q[15:11];
  assign imm16      = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch timing, decode, next-PC cases, pc_err,
// stray acks and reset during a fetch.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start, PCWre, Branch, Jump, Zero, imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req, ir_valid, fetch_busy, pc_err, dbg_state;
  logic [31:0] imem_addr, pc, pc_plus4;
  logic [5:0]  Opcode, func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  logic        b_imem_req, b_ir_valid, b_fetch_busy, b_pc_err, b_dbg_state;
  logic [31:0] b_imem_addr, b_pc, b_pc_plus4;
  logic [5:0]  b_Opcode, b_func;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [15:0] b_imm16;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .PCWre(PCWre),
    .Branch(Branch), .Jump(Jump), .Zero(Zero), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Opcode(Opcode), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .pc(pc), .pc_plus4(pc_plus4), .ir_valid(ir_valid), .fetch_busy(fetch_busy),
    .pc_err(pc_err), .dbg_state(dbg_state)
  );

  // Second instance with a high reset PC, driven identically, for the j-target upper nibble.
  instr_fetch_unit #(.RESET_PC(32'h8000_0010)) dut_b (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .PCWre(PCWre),
    .Branch(Branch), .Jump(Jump), .Zero(Zero), .imem_req(b_imem_req),
    .imem_addr(b_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Opcode(b_Opcode), .func(b_func), .rs(b_rs), .rt(b_rt), .rd(b_rd), .imm16(b_imm16),
    .pc(b_pc), .pc_plus4(b_pc_plus4), .ir_valid(b_ir_valid), .fetch_busy(b_fetch_busy),
    .pc_err(b_pc_err), .dbg_state(b_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Pulse fetch_start, hold the request for lat cycles, ack with word on the last.
  task automatic fetch(input logic [31:0] word, input int lat, input logic [31:0] exp_addr);
    fetch_start = 1'b1;
    cycle();
    fetch_start = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check("req_high", {31'b0, imem_req}, 32'd1);
      check("req_addr", imem_addr, exp_addr);
      if (i == lat - 1) begin
        imem_ack   = 1'b1;
        imem_rdata = word;
      end
      cycle();
    end
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("req_low", {31'b0, imem_req}, 32'd0);
    check("ir_valid_set", {31'b0, ir_valid}, 32'd1);
  endtask

  task automatic pc_update(input logic j, input logic b, input logic z, input logic [31:0] exp_pc);
    PCWre = 1'b1; Jump = j; Branch = b; Zero = z;
    cycle();
    PCWre = 1'b0; Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    check("pc_upd", pc, exp_pc);
    check("ir_valid_clr", {31'b0, ir_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; fetch_start = 1'b0; PCWre = 1'b0; Branch = 1'b0; Jump = 1'b0;
    Zero = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) cycle();
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_addr", imem_addr, 32'h0000_3000);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_busy", {31'b0, fetch_busy}, 32'd0);
    check("rst_irv", {31'b0, ir_valid}, 32'd0);
    check("rst_err", {31'b0, pc_err}, 32'd0);
    check("rst_op", {26'b0, Opcode}, 32'd0);
    check("rst_imm", {16'b0, imm16}, 32'd0);
    check("rst_b_pc", b_pc, 32'h8000_0010);
    rst_n = 1'b1;
    cycle();

    // R-type add $3,$1,$2 with a 3-cycle memory
    fetch(32'h0022_1820, 3, 32'h0000_3000);
    check("dec_op", {26'b0, Opcode}, 32'd0);
    check("dec_func", {26'b0, func}, 32'h20);
    check("dec_rs", {27'b0, rs}, 32'd1);
    check("dec_rt", {27'b0, rt}, 32'd2);
    check("dec_rd", {27'b0, rd}, 32'd3);

    // j 0x40 with Branch/Zero also high: Jump wins
    fetch(32'h0800_0040, 1, 32'h0000_3000);
    pc_update(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    check("b_j_pc", b_pc, 32'h8000_0100);
    check("b_j_irv", {31'b0, b_ir_valid}, 32'd0);
    check("pc_plus4", pc_plus4, 32'h0000_0104);

    // beq taken / not taken / negative offset
    fetch(32'h1022_0004, 2, 32'h0000_0100);
    check("beq_op", {26'b0, Opcode}, 32'd4);
    check("beq_imm", {16'b0, imm16}, 32'h0004);
    pc_update(1'b0, 1'b1, 1'b1, 32'h0000_0114);
    fetch(32'h0800_0040, 1, 32'h0000_0114);
    pc_update(1'b1, 1'b0, 1'b0, 32'h0000_0100);
    fetch(32'h1022_0004, 1, 32'h0000_0100);
    pc_update(1'b0, 1'b1, 1'b0, 32'h0000_0104);
    fetch(32'h0800_0040, 1, 32'h0000_0104);
    pc_update(1'b1, 1'b0, 1'b0, 32'h0000_0100);
    fetch(32'h1022_FFFF, 1, 32'h0000_0100);
    pc_update(1'b0, 1'b1, 1'b1, 32'h0000_0100);

    // Branch wrapping below zero, then sequential wrap past the top
    fetch(32'h1022_FFBE, 1, 32'h0000_0100);
    pc_update(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check("wrap_p4", pc_plus4, 32'h0000_0000);
    pc_update(1'b0, 1'b0, 1'b0, 32'h0000_0000);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // PCWre with fetch_start in IDLE: fetch uses the updated PC
    PCWre = 1'b1; fetch_start = 1'b1;
    cycle();
    PCWre = 1'b0; fetch_start = 1'b0;
    check("cmb_pc", pc, 32'h0000_0004);
    check("cmb_addr", imem_addr, 32'h0000_0004);
    check("cmb_dbg", {31'b0, dbg_state}, 32'd1);

    // Illegal PCWre and repeat fetch_start during REQ
    PCWre = 1'b1; fetch_start = 1'b1; Jump = 1'b1;
    cycle();
    PCWre = 1'b0; fetch_start = 1'b0; Jump = 1'b0;
    check("err_pc", pc, 32'h0000_0004);
    check("err_flag", {31'b0, pc_err}, 32'd1);
    check("err_busy", {31'b0, fetch_busy}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hAC41_0008;
    cycle();
    imem_ack = 1'b0;
    check("err_ir_op", {26'b0, Opcode}, 32'h2B);
    check("err_req_low", {31'b0, imem_req}, 32'd0);
    // Stray ack in IDLE
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    cycle();
    imem_ack = 1'b0;
    check("stray_imm", {16'b0, imm16}, 32'h0008);
    check("stray_req", {31'b0, imem_req}, 32'd0);
    check("err_sticky", {31'b0, pc_err}, 32'd1);

    // Reset in the middle of a request
    fetch_start = 1'b1;
    cycle();
    fetch_start = 1'b0;
    check("mid_req", {31'b0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req", {31'b0, imem_req}, 32'd0);
    cycle();
    #2 rst_n = 1'b1;
    cycle();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    cycle();
    imem_ack = 1'b0;
    check("post_pc", pc, 32'h0000_3000);
    check("post_op", {26'b0, Opcode}, 32'd0);
    check("post_imm", {16'b0, imm16}, 32'd0);
    check("post_irv", {31'b0, ir_valid}, 32'd0);
    check("post_req", {31'b0, imem_req}, 32'd0);
    check("post_err", {31'b0, pc_err}, 32'd0);
    check("post_b_pc", b_pc, 32'h8000_0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
